alu_issue_scheduler: RTL and testbench

Out-of-order issue scheduler between rename/dispatch and the ALU functional unit. Buffers up to DEPTH renamed ALU instructions and tracks source-operand readiness through writeback tag broadcasts. Each cycle it offers the oldest instruction with both sources ready to the ALU over a valid/ready handshake. Entries are squashed on pipeline flush.

---
 rtl/alu_issue_scheduler_pkg.sv | 43 ++++
 rtl/alu_issue_scheduler_oldest_ready_select.sv | 27 ++
 rtl/alu_issue_scheduler.sv | 178 +++++++++++++++++
 tb/tb_alu_issue_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_scheduler_pkg
//  Description : Shared types and constants for the ALU issue scheduler.
//                This package defines the issue-queue entry layout, the
//                default queue depth, and the source-readiness helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_scheduler_pkg;

    localparam int PREG_W   = 7;
    localparam int ROB_W    = 4;
    localparam int IQ_DEPTH = 8;
    localparam int c_XLEN   = 32;

    // One renamed ALU instruction. The rdy bits travel with the payload so
    // the issue port always shows the live readiness of the selected slot.
    typedef struct packed {
        logic [c_XLEN-1:0] pc;
        logic [c_XLEN-1:0] imm;
        logic [3:0]        alu_op;
        logic [6:0]        opcode;
        logic [PREG_W-1:0] prs1;
        logic [PREG_W-1:0] prs2;
        logic [PREG_W-1:0] prd;
        logic [ROB_W-1:0]  rob_tag;
        logic              rs1_rdy;
        logic              rs2_rdy;
    } iq_entry_t;

    // A source is ready if dispatch says so, if it is the hardwired zero
    // register, or if it is being written back in this very cycle.
    function automatic logic src_ready(
        input logic              pend_rdy,
        input logic [PREG_W-1:0] prs,
        input logic              wb_valid,
        input logic [PREG_W-1:0] wb_tag
    );
        return pend_rdy | (prs == '0) | (wb_valid & (wb_tag == prs));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_scheduler_oldest_ready_select.sv
`default_nettype none
// ============================================================================
//  Module      : oldest_ready_select
//  Description : Combinational age-matrix picker. It grants the one candidate
//                that has no older candidate.
//                i_older[i][j] = 1 means slot j is older than slot i.
//  Revision    : 1.0 - initial release
// ============================================================================
module oldest_ready_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]            i_cand,
    input  logic [DEPTH-1:0][DEPTH-1:0] i_older,
    output logic [DEPTH-1:0]            o_grant,
    output logic                        o_found
);

    // A slot wins when it is a candidate and none of its elders are.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_grant
        assign o_grant[gi] = i_cand[gi] & ~|(i_older[gi] & i_cand);
    end

    // The age order among valid slots is total, so any candidate yields a winner.
    assign o_found = |i_cand;

endmodule
`default_nettype wire

// File: rtl/alu_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_scheduler
//  Description : Out-of-order ALU issue queue. It holds up to DEPTH renamed
//                instructions, wakes sources on writeback broadcasts, and
//                offers the oldest ready entry over a valid/ready handshake.
//                A stalled offer is pinned until it is accepted or squashed.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_scheduler
    import alu_issue_scheduler_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int PREG_W = alu_issue_scheduler_pkg::PREG_W,
    parameter int ROB_W  = alu_issue_scheduler_pkg::ROB_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   disp_valid,
    output logic                   disp_ready,
    input  iq_entry_t              disp_entry,
    input  logic                   wb_valid,
    input  logic [PREG_W-1:0]      wb_tag,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output iq_entry_t              issue_entry,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_OCC_W = $clog2(DEPTH) + 1;

    // Slot storage and bookkeeping
    logic [DEPTH-1:0]            r_valid;
    iq_entry_t                   r_entry [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] r_older;
    logic                        r_hold_valid;
    logic [c_IDX_W-1:0]          r_hold_idx;
    logic [c_OCC_W-1:0]          r_occ;

    // Combinational control
    logic [DEPTH-1:0]   w_cand;
    logic [DEPTH-1:0]   w_grant;
    logic               w_found;
    logic [c_IDX_W-1:0] w_grant_idx;
    logic [c_IDX_W-1:0] w_sel_idx;
    logic [c_IDX_W-1:0] w_alloc_idx;
    logic               w_kill;
    logic               w_offer;
    logic               w_issue_fire;
    logic               w_disp_fire;
    logic [ROB_W-1:0]   w_issue_rob;
    iq_entry_t          w_new_entry;

    // A slot may issue once it is valid and both sources are ready.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cand
        assign w_cand[gi] = r_valid[gi] & r_entry[gi].rs1_rdy & r_entry[gi].rs2_rdy;
    end

    oldest_ready_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .i_cand  (w_cand),
        .i_older (r_older),
        .o_grant (w_grant),
        .o_found (w_found)
    );

    // Encode the one-hot grant into a slot index.
    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = c_IDX_W'(i);
            end
        end
    end

    // Pick the lowest-index free slot for the next dispatch.
    always_comb begin
        w_alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_alloc_idx = c_IDX_W'(i);
            end
        end
    end

    // A stalled offer keeps its slot; otherwise the age matrix decides.
    assign w_kill       = reset | flush;
    assign w_sel_idx    = r_hold_valid ? r_hold_idx : w_grant_idx;
    assign w_offer      = r_hold_valid | w_found;
    assign issue_valid  = w_offer & ~w_kill;
    assign w_issue_fire = issue_valid & issue_ready;

    // Full is judged on registered occupancy, so a same-cycle issue never
    // opens a slot for a same-cycle dispatch.
    assign disp_ready  = (r_occ < c_OCC_W'(DEPTH)) & ~reset;
    assign w_disp_fire = disp_valid & disp_ready & ~flush;
    assign occupancy   = r_occ;

    assign w_issue_rob = r_entry[w_sel_idx].rob_tag;

    // Build the incoming entry with the same-cycle wakeup bypass applied.
    always_comb begin
        w_new_entry         = disp_entry;
        w_new_entry.rs1_rdy = src_ready(disp_entry.rs1_rdy, disp_entry.prs1, wb_valid, wb_tag);
        w_new_entry.rs2_rdy = src_ready(disp_entry.rs2_rdy, disp_entry.prs2, wb_valid, wb_tag);
    end

    // Present the selected slot, or zeros when nothing is offered.
    always_comb begin
        issue_entry = '0;
        if (w_offer) begin
            issue_entry         = r_entry[w_sel_idx];
            issue_entry.rob_tag = w_issue_rob;
        end
    end

    // Slot state: wakeup, issue free and allocation with age-row update.
    always_ff @(posedge clk) begin
        if (w_kill) begin
            r_valid <= '0;
            r_older <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i] && wb_valid) begin
                    if (r_entry[i].prs1 == wb_tag) begin
                        r_entry[i].rs1_rdy <= 1'b1;
                    end
                    if (r_entry[i].prs2 == wb_tag) begin
                        r_entry[i].rs2_rdy <= 1'b1;
                    end
                end
            end
            if (w_issue_fire) begin
                r_valid[w_sel_idx] <= 1'b0;
            end
            if (w_disp_fire) begin
                r_valid[w_alloc_idx] <= 1'b1;
                r_entry[w_alloc_idx] <= w_new_entry;
                // Nobody treats the reused slot as older any more.
                for (int i = 0; i < DEPTH; i++) begin
                    r_older[i][w_alloc_idx] <= 1'b0;
                end
                // Everything already resident is older than the newcomer.
                r_older[w_alloc_idx] <= r_valid;
            end
        end
    end

    // Hold register for stalled offers and the occupancy counter.
    always_ff @(posedge clk) begin
        if (w_kill) begin
            r_hold_valid <= 1'b0;
            r_hold_idx   <= '0;
            r_occ        <= '0;
        end else begin
            if (issue_valid && !issue_ready) begin
                r_hold_valid <= 1'b1;
                r_hold_idx   <= w_sel_idx;
            end else if (w_issue_fire) begin
                r_hold_valid <= 1'b0;
            end
            case ({w_disp_fire, w_issue_fire})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_scheduler
//  Description : Self-checking bench for alu_issue_scheduler. Per-cycle vector
//                records drive and check the outputs. A queue holds the
//                expected issue order, and it is compared on every handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_scheduler;
    import alu_issue_scheduler_pkg::*;

    typedef struct {
        logic        dv;
        logic [31:0] pc;
        logic [6:0]  p1;
        logic [6:0]  p2;
        logic        r1;
        logic        r2;
        logic        wv;
        logic [6:0]  wt;
        logic        ir;
        logic        fl;
        logic        e_iv;
        logic [31:0] e_pc;
        logic [3:0]  e_occ;
        logic        e_dr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    iq_entry_t   disp_entry;
    logic        wb_valid;
    logic [6:0]  wb_tag;
    logic        issue_valid;
    logic        issue_ready;
    iq_entry_t   issue_entry;
    logic [3:0]  occupancy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q [$];
    vec_t        tbl [12];

    always #5 clk = ~clk;

    alu_issue_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .disp_entry  (disp_entry),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_entry (issue_entry),
        .occupancy   (occupancy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic dv, input logic [31:0] pc, input logic [6:0] p1, input logic [6:0] p2,
        input logic r1, input logic r2, input logic wv, input logic [6:0] wt,
        input logic ir, input logic fl,
        input logic e_iv, input logic [31:0] e_pc, input logic [3:0] e_occ, input logic e_dr
    );
        vec_t v;
        v.dv = dv; v.pc = pc; v.p1 = p1; v.p2 = p2; v.r1 = r1; v.r2 = r2;
        v.wv = wv; v.wt = wt; v.ir = ir; v.fl = fl;
        v.e_iv = e_iv; v.e_pc = e_pc; v.e_occ = e_occ; v.e_dr = e_dr;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs, check the outputs, queue any accepted issue.
    task automatic step(input string tag, input vec_t v);
        logic [31:0] pcv;
        pcv                = v.pc;
        disp_valid         = v.dv;
        disp_entry         = '0;
        disp_entry.pc      = pcv;
        disp_entry.imm     = pcv ^ 32'h0000_0055;
        disp_entry.alu_op  = pcv[5:2];
        disp_entry.opcode  = 7'h33;
        disp_entry.prs1    = v.p1;
        disp_entry.prs2    = v.p2;
        disp_entry.prd     = pcv[8:2];
        disp_entry.rob_tag = pcv[5:2];
        disp_entry.rs1_rdy = v.r1;
        disp_entry.rs2_rdy = v.r2;
        wb_valid           = v.wv;
        wb_tag             = v.wt;
        issue_ready        = v.ir;
        flush              = v.fl;
        #1;
        check({tag, ".issue_valid"}, issue_valid, v.e_iv);
        check({tag, ".occupancy"}, occupancy, v.e_occ);
        check({tag, ".disp_ready"}, disp_ready, v.e_dr);
        if (v.e_iv) begin
            check({tag, ".issue_pc"}, issue_entry.pc, v.e_pc);
            check({tag, ".issue_rdy"}, {issue_entry.rs1_rdy, issue_entry.rs2_rdy}, 2'b11);
            if (v.ir) begin
                sb_q.push_back(v.e_pc);
            end
        end
        tick();
    endtask

    // On every accepted handshake, compare against the next expected issue.
    always @(negedge clk) begin
        if (!reset && issue_valid && issue_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_issue actual=%0h expected=none", issue_entry.pc);
            end else begin
                check("sb_issue_pc", issue_entry.pc, sb_q.pop_front());
            end
        end
    end

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        disp_valid  = 1'b0;
        disp_entry  = '0;
        wb_valid    = 1'b0;
        wb_tag      = '0;
        issue_ready = 1'b0;
        tick();
        tick();
        check("rst.issue_valid", issue_valid, 1'b0);
        check("rst.disp_ready_in_reset", disp_ready, 1'b0);
        check("rst.occupancy", occupancy, 4'd0);
        reset = 1'b0;
        #1;
        check("rst.disp_ready_after", disp_ready, 1'b1);
        check("rst.issue_entry_zero", issue_entry, 128'd0);
        tick();

        // Single issue, oldest-ready over a blocked elder, then same-cycle wakeup bypass.
        tbl[0]  = mk(1, 'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,      0, 1);
        tbl[1]  = mk(0, 0,     0, 0, 0, 0, 0, 0, 1, 0, 1, 'h100, 1, 1);
        tbl[2]  = mk(0, 0,     0, 0, 0, 0, 0, 0, 1, 0, 0, 0,      0, 1);
        tbl[3]  = mk(1, 'h200, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 1);
        tbl[4]  = mk(1, 'h210, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 1);
        tbl[5]  = mk(0, 0,     0, 0, 0, 0, 0, 0, 1, 0, 1, 'h210, 2, 1);
        tbl[6]  = mk(0, 0,     0, 0, 0, 0, 1, 5, 1, 0, 0, 0,      1, 1);
        tbl[7]  = mk(0, 0,     0, 0, 0, 0, 0, 0, 1, 0, 1, 'h200, 1, 1);
        tbl[8]  = mk(0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 1);
        tbl[9]  = mk(1, 'h300, 0, 9, 0, 0, 1, 9, 1, 0, 0, 0,      0, 1);
        tbl[10] = mk(0, 0,     0, 0, 0, 0, 0, 0, 1, 0, 1, 'h300, 1, 1);
        tbl[11] = mk(0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 1);
        for (int i = 0; i < 12; i++) begin
            step($sformatf("tbl%0d", i), tbl[i]);
        end

        // Fill all slots with pending sources; dispatch stalls while full.
        for (int i = 0; i < 8; i++) begin
            step($sformatf("fill%0d", i),
                 mk(1, 32'h400 + 32'(4 * i), 7'(20 + i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'(i), 1));
        end
        step("full_stall",  mk(1, 'h4f0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,      8, 0));
        step("full_wake",   mk(1, 'h4f0, 0, 0, 0, 0, 1, 23, 0, 0, 0, 0,      8, 0));
        step("full_issue",  mk(1, 'h4f0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 'h40c, 8, 0));
        step("full_reopen", mk(1, 'h500, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,      7, 1));
        step("full_again",  mk(0, 0,     0, 0, 0, 0, 0,  0, 0, 0, 1, 'h500, 8, 0));
        step("full_flush",  mk(0, 0,     0, 0, 0, 0, 0,  0, 1, 1, 0, 0,      8, 0));
        step("post_flush",  mk(0, 0,     0, 0, 0, 0, 0,  0, 1, 0, 0, 0,      0, 1));
        step("ghost_wake",  mk(0, 0,     0, 0, 0, 0, 1, 20, 1, 0, 0, 0,      0, 1));
        step("ghost_idle",  mk(0, 0,     0, 0, 0, 0, 0,  0, 1, 0, 0, 0,      0, 1));

        // Hold: a stalled offer stays pinned while an older entry wakes.
        step("hold0", mk(1, 'h600, 30, 0, 0, 0, 0,  0, 0, 0, 0, 0,      0, 1));
        step("hold1", mk(1, 'h610,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,      1, 1));
        step("hold2", mk(1, 'h620,  0, 0, 0, 0, 0,  0, 0, 0, 1, 'h610, 2, 1));
        step("hold3", mk(0, 0,      0, 0, 0, 0, 1, 30, 0, 0, 1, 'h610, 3, 1));
        step("hold4", mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0, 1, 'h610, 3, 1));
        step("hold5", mk(0, 0,      0, 0, 0, 0, 0,  0, 1, 0, 1, 'h610, 3, 1));
        step("hold6", mk(0, 0,      0, 0, 0, 0, 0,  0, 1, 0, 1, 'h600, 2, 1));
        step("hold7", mk(0, 0,      0, 0, 0, 0, 0,  0, 1, 0, 1, 'h620, 1, 1));
        step("hold8", mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0, 0, 0,      0, 1));

        // Flush with five valid entries during an accepted offer; a dispatch in the flush cycle is dropped.
        for (int i = 0; i < 5; i++) begin
            step($sformatf("fl_fill%0d", i),
                 mk(1, 32'h700 + 32'(4 * i), 0, 0, 0, 0, 0, 0, 0, 0, (i != 0), 'h700, 4'(i), 1));
        end
        step("fl_cycle", mk(1, 'h7f0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 5, 1));
        step("fl_after", mk(0, 0,     0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        step("fl_idle",  mk(0, 0,     0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));

        // Reset in the middle of a handshake drops the offer.
        step("rm_disp", mk(1, 'h800, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        reset       = 1'b1;
        disp_valid  = 1'b0;
        issue_ready = 1'b1;
        #1;
        check("rm.issue_valid_in_reset", issue_valid, 1'b0);
        check("rm.disp_ready_in_reset", disp_ready, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        check("rm.occupancy", occupancy, 4'd0);
        check("rm.issue_valid", issue_valid, 1'b0);
        check("rm.disp_ready", disp_ready, 1'b1);
        check("rm.issue_entry_zero", issue_entry, 128'd0);
        issue_ready = 1'b0;
        tick();
        tick();

        check("sb_leftover", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
